// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its fetch queue.
`include "constants.vh"

package fetch_pkg;

  typedef struct packed {
    logic [`XLEN-1:0]        pc;
    logic [`INSTR_WIDTH-1:0] instr;
  } fq_entry_t;

  localparam logic [`XLEN-1:0] PC_STEP = `XLEN'(4);

  localparam int unsigned FQ_DEPTH_DEFAULT = 4;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/constants.vh
// Global datapath widths shared by the fetch-side RTL.
`ifndef CONSTANTS_VH
`define CONSTANTS_VH
`define XLEN 32
`define INSTR_WIDTH 32
`endif

// File: rtl/fetch_queue.sv
// Circular {pc, instr} buffer: one push, zero to two pops per cycle, flush,
// and two combinational read ports for the oldest two entries.
`include "constants.vh"

module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH_DEFAULT,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  fq_entry_t     push_data,
  input  logic [1:0]    pop_cnt,
  output logic [CW-1:0] count,
  output fq_entry_t     rd0,
  output fq_entry_t     rd1
);

  fq_entry_t     mem [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  // pop_cnt is trusted to never exceed count_q; the caller clamps it.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + AW'(pop_cnt);
      tail_d  = tail_q + AW'(push);
      count_d = count_q - CW'(pop_cnt) + CW'(push);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only observed while counted valid.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[tail_q] <= push_data;
    end
  end

  always_comb begin
    rd0   = mem[head_q];
    rd1   = mem[head_q + AW'(1)];
    count = count_q;
  end

endmodule

// File: rtl/ifetch_unit.sv
// Fetch-side imem initiator: owns the fetch PC, push/redirect control and the
// fetch queue feeding the dual-issue decode stage.
`include "constants.vh"

module ifetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned      FQ_DEPTH = FQ_DEPTH_DEFAULT,
  parameter logic [`XLEN-1:0] RESET_PC = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic [`XLEN-1:0]              imem_pc,
  input  logic [`INSTR_WIDTH-1:0]       imem_instr,
  input  logic                          redirect_valid,
  input  logic [`XLEN-1:0]              redirect_pc,
  input  logic [1:0]                    deq_count,
  output logic                          out_valid0,
  output logic [`XLEN-1:0]              out_pc0,
  output logic [`INSTR_WIDTH-1:0]       out_instr0,
  output logic                          out_valid1,
  output logic [`XLEN-1:0]              out_pc1,
  output logic [`INSTR_WIDTH-1:0]       out_instr1,
  output logic [$clog2(FQ_DEPTH):0]     fq_count
);

  localparam int unsigned CW = cnt_width(FQ_DEPTH);

  logic [`XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]       deq_clamp;
  logic [1:0]       eff_deq;
  logic [1:0]       pop_cnt;
  logic             push;
  logic [CW-1:0]    count;
  fq_entry_t        push_data;
  fq_entry_t        rd0, rd1;

  always_comb begin
    deq_clamp  = (deq_count == 2'd3) ? 2'd2 : deq_count;
    eff_deq    = (CW'(deq_clamp) > count) ? count[1:0] : deq_clamp;
    pop_cnt    = 2'd0;
    push       = 1'b0;
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[`XLEN-1:2], 2'b00};
    end else begin
      pop_cnt = eff_deq;
      // Comparing post-dequeue occupancy lets a full queue push while draining.
      push    = (count - CW'(eff_deq)) < CW'(FQ_DEPTH);
      if (push) begin
        fetch_pc_d = fetch_pc_q + PC_STEP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
    end
  end

  assign push_data = '{pc: fetch_pc_q, instr: imem_instr};

  fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_fetch_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_data),
    .pop_cnt   (pop_cnt),
    .count     (count),
    .rd0       (rd0),
    .rd1       (rd1)
  );

  always_comb begin
    imem_pc    = fetch_pc_q;
    out_valid0 = (count >= CW'(1));
    out_valid1 = (count >= CW'(2));
    out_pc0    = rd0.pc;
    out_instr0 = rd0.instr;
    out_pc1    = rd1.pc;
    out_instr1 = rd1.instr;
    fq_count   = count;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n && !redirect_valid) begin
      over_deq_a: assert (CW'(deq_clamp) <= count)
        else $warning("ifetch_unit: dequeue of %0d exceeds occupancy %0d, clamped",
                      deq_clamp, count);
    end
  end
`endif

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Fetch-side initiator for the instruction memory. Drives the word-aligned fetch PC onto the imem address port and captures the combinationally returned instruction.
- Buffers {pc, instr} pairs in a small circular fetch queue that presents up to two in-order instructions per cycle to the dual-issue decode stage.
- Handles back-pressure from decode and PC redirects from branch/jump resolution.

Parameters:
- FQ_DEPTH, 4, fetch-queue entries; power of two, minimum 2.
- RESET_PC, 32'h0000_0000, fetch address after reset; bits [1:0] must be 0.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- imem_pc  output  `XLEN  fetch address to imem; imem indexes words with pc[31:2].
- imem_instr  input  `INSTR_WIDTH  instruction returned combinationally for imem_pc in the same cycle.
- redirect_valid  input  1  flush the queue and restart fetch.
- redirect_pc  input  `XLEN  new fetch address.
- deq_count  input  2  entries consumed by decode this cycle (0, 1, 2; 3 treated as 2).
- out_valid0  output  1  slot 0 holds a valid entry (oldest).
- out_pc0  output  `XLEN  PC of slot 0.
- out_instr0  output  `INSTR_WIDTH  instruction of slot 0.
- out_valid1  output  1  slot 1 holds a valid entry (second oldest).
- out_pc1  output  `XLEN  PC of slot 1.
- out_instr1  output  `INSTR_WIDTH  instruction of slot 1.
- fq_count  output  $clog2(FQ_DEPTH)+1  current occupancy.

Behaviour:
- Reset, with rst_n low at a clk edge:
  - fetch_pc = RESET_PC; imem_pc = RESET_PC.
  - head, tail and count = 0.
  - out_valid0 = out_valid1 = 0; fq_count = 0.
  - out_pc*/out_instr* are don't-care while invalid; the bench must not check them.
- imem_pc = fetch_pc, registered. There is no separate request handshake because imem has zero read latency.
- Effective dequeue: eff_deq = min(deq_count clamped to 2, count). Over-dequeue is ignored and raises a simulation assertion.
- Push condition, evaluated each cycle without redirect: (count - eff_deq) < FQ_DEPTH.
  - A full queue may push in the same cycle it dequeues.
  - On push: write {fetch_pc, imem_instr} at tail; tail += 1 mod FQ_DEPTH; fetch_pc += 4.
  - No push: fetch_pc holds, and imem_pc holds with it.
- Next count = count - eff_deq + push. Head advances by eff_deq mod FQ_DEPTH.
- Outputs are combinational from queue state:
  - out_valid0 = (count >= 1); out_valid1 = (count >= 2).
  - Slot 0 = entry[head]; slot 1 = entry[head+1 mod FQ_DEPTH].
  - Both slots are visible in the cycle after the entry is written. There is no same-cycle bypass from imem to the outputs.
- Redirect (redirect_valid=1) has priority over all else:
  - Next cycle: count = 0, head = tail = 0, fetch_pc = {redirect_pc[31:2], 2'b00}.
  - No push and no dequeue in the redirect cycle; deq_count is ignored.
  - The first post-redirect entry is written the following cycle and is visible one cycle after that, giving a 2-cycle redirect-to-valid latency.
- Back-to-back redirects: the latest wins; the queue stays empty.
- PC wrap: fetch_pc increments modulo 2^32 (32'hFFFF_FFFC + 4 = 0). No exception is raised.
- Reset asserted mid-operation overrides redirect and dequeue; all state returns to reset values at that edge.
- Ordering: entries leave in exact fetch order, and out_pc1 = out_pc0 + 4 unless a wrap occurred.

Decomposition:
- fetch_pkg holds:
  - fq_entry_t struct {logic [`XLEN-1:0] pc; logic [`INSTR_WIDTH-1:0] instr;}.
  - localparam PC_STEP = 4.
  - FQ_DEPTH default and count-width helper.
- `XLEN and `INSTR_WIDTH continue to come from constants.vh.
- One sub-module, fetch_queue: a circular buffer with 1 push and 0–2 pops, flush input, count output and two read ports.
- ifetch_unit keeps fetch_pc, the push/redirect control and the imem interface.

Test Plan:
- Reset, then release; no deq; imem model returns instr = pc>>2 → imem_pc steps 0,4,8,12. After 4 pushes: fq_count=4, imem_pc holds at 16, out_pc0=0, out_instr0=0, out_pc1=4, out_instr1=1.
- Full queue with deq_count=2 for one cycle → same edge pushes pc 16. fq_count=3; out_pc0=8, out_pc1=12; imem_pc=20.
- Steady deq_count=1 from reset → after fill, fq_count stays at 1–2 and the PC sequence is monotonic +4 with no gaps or duplicates. Scoreboard checks 100 instructions.
- redirect_valid with redirect_pc=32'h0000_0103 while queue holds 3 entries:
  - Next cycle: fq_count=0, out_valid0=0, imem_pc=32'h100.
  - Two cycles later: out_valid0=1, out_pc0=32'h100.
- Start at RESET_PC=32'hFFFF_FFF8 → entries at FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004 in order.
- deq_count=2 while fq_count=1 → eff_deq=1, fq_count=0 plus push; assertion fires. Separately, rst_n low during an active redirect → all outputs reach reset values next edge and imem_pc=RESET_PC.
